// File: rtl/b1_fe_pkg.sv
// Shared types and helpers for the B1 front-end conditioner: sample/gain widths,
// 8-bit saturation and magnitude.
package b1_fe_pkg;

  localparam int SMP_W  = 8;
  localparam int GAIN_W = 4;
  localparam int CALC_W = 32;

  function automatic logic signed [SMP_W-1:0] sat8(input logic signed [CALC_W-1:0] v);
    if (v > 32'sd127)
      return 8'sd127;
    else if (v < -32'sd128)
      return -8'sd128;
    else
      return v[SMP_W-1:0];
  endfunction

  // |-128| is 128, which still fits the unsigned 8-bit result.
  function automatic logic [SMP_W-1:0] mag8(input logic signed [SMP_W-1:0] s);
    logic [SMP_W-1:0] m;
    m = s[SMP_W-1] ? (~s + 8'd1) : s;
    return m;
  endfunction

endpackage

// File: rtl/b1_dc_rem.sv
// Stage-1 DC-offset removal with a leaky-integrator estimate, one register of latency.
// Estimator is built only when B1_FE_DCREM_EN is defined; otherwise the sample is just registered.
module b1_dc_rem
  import b1_fe_pkg::*;
#(
  parameter int ADC_WIDTH = 12,
  parameter int DC_SHIFT  = 12
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst,
  input  logic signed [ADC_WIDTH-1:0] adc_i,
  input  logic                        vld_i,
  output logic signed [ADC_WIDTH-1:0] x_o,
  output logic                        vld_o
);

  logic signed [ADC_WIDTH-1:0] x_q, x_d;
  logic                        vld_q;

`ifdef B1_FE_DCREM_EN
  localparam int ACC_W = ADC_WIDTH + DC_SHIFT + 1;
  localparam int DIF_W = ADC_WIDTH + 2;
  localparam logic signed [DIF_W-1:0] X_MAX = DIF_W'((1 <<< (ADC_WIDTH - 1)) - 1);
  localparam logic signed [DIF_W-1:0] X_MIN = DIF_W'(-(1 <<< (ADC_WIDTH - 1)));

  logic signed [ACC_W-1:0] acc_q, acc_d, dc_est;
  logic signed [DIF_W-1:0] diff;

  // The subtraction uses the estimate from before this sample's accumulator update.
  always_comb begin
    dc_est = acc_q >>> DC_SHIFT;
    diff   = DIF_W'(adc_i) - DIF_W'(dc_est);
    acc_d  = acc_q;
    x_d    = x_q;
    if (vld_i) begin
      acc_d = acc_q + ACC_W'(adc_i) - dc_est;
      if (diff > X_MAX)
        x_d = X_MAX[ADC_WIDTH-1:0];
      else if (diff < X_MIN)
        x_d = X_MIN[ADC_WIDTH-1:0];
      else
        x_d = diff[ADC_WIDTH-1:0];
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) acc_q <= '0;
    else         acc_q <= acc_d;
  end
`else
  always_comb begin
    x_d = vld_i ? adc_i : x_q;
  end
`endif

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      x_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      vld_q <= vld_i;
    end
  end

  assign x_o   = x_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/b1_frontend_agc.sv
// B1 receive front end: DC removal (B1_FE_DCREM_EN), power-of-two gain with 8-bit
// saturation, and a windowed AGC loop with lock detection.
module b1_frontend_agc
  import b1_fe_pkg::*;
#(
  parameter int ADC_WIDTH = 12,
  parameter int WIN_LOG2  = 10,
  parameter int GAIN_MAX  = 7,
  parameter int GAIN_INIT = 3,
  parameter int MAG_THR   = 64,
  parameter int CNT_HI    = 384,
  parameter int CNT_LO    = 128,
  parameter int LOCK_WINS = 4,
  parameter int DC_SHIFT  = 12
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst,
  input  logic signed [ADC_WIDTH-1:0] rx_adc,
  input  logic                        rx_adc_vld,
  input  logic                        rx_agc_hold,
  output logic signed [SMP_W-1:0]     tx_src,
  output logic                        tx_src_vld,
  output logic [GAIN_W-1:0]           tx_agc_gain,
  output logic                        tx_agc_lock
);

  localparam int HC_W = WIN_LOG2 + 1;
  localparam int LK_W = $clog2(LOCK_WINS + 1);

  logic signed [ADC_WIDTH-1:0] x_dc;
  logic                        x_vld;
  logic signed [CALC_W-1:0]    scaled;
  logic signed [SMP_W-1:0]     y;
  logic                        y_high, last_smp;
  logic [HC_W-1:0]             hcnt_sum;

  logic [WIN_LOG2-1:0]     wcnt_q, wcnt_d;
  logic [HC_W-1:0]         hcnt_q, hcnt_d;
  logic                    win_end_q, win_end_d;
  logic                    hi_q, hi_d, lo_q, lo_d;
  logic [GAIN_W-1:0]       gain_q, gain_d;
  logic [LK_W-1:0]         lock_cnt_q, lock_cnt_d;
  logic                    lock_q, lock_d;
  logic signed [SMP_W-1:0] src_q, src_d;
  logic                    src_vld_q;

  b1_dc_rem #(
    .ADC_WIDTH (ADC_WIDTH),
    .DC_SHIFT  (DC_SHIFT)
  ) u_dc_rem (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .adc_i  (rx_adc),
    .vld_i  (rx_adc_vld),
    .x_o    (x_dc),
    .vld_o  (x_vld)
  );

  // Window counter runs down; terminal count 0 marks the window's last sample.
  always_comb begin
    scaled    = (CALC_W'(x_dc) <<< gain_q) >>> (ADC_WIDTH - SMP_W);
    y         = sat8(scaled);
    y_high    = mag8(y) >= SMP_W'(MAG_THR);
    last_smp  = x_vld && (wcnt_q == '0);
    hcnt_sum  = hcnt_q + HC_W'(y_high);
    wcnt_d    = x_vld ? wcnt_q - 1'b1 : wcnt_q;
    hcnt_d    = x_vld ? (last_smp ? '0 : hcnt_sum) : hcnt_q;
    win_end_d = last_smp;
    hi_d      = last_smp ? (hcnt_sum > HC_W'(CNT_HI)) : hi_q;
    lo_d      = last_smp ? (hcnt_sum < HC_W'(CNT_LO)) : lo_q;
    src_d     = x_vld ? y : src_q;
  end

  // Gain decision runs the cycle after the window closes; clamps and hold count as unchanged.
  always_comb begin
    gain_d     = gain_q;
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    if (win_end_q) begin
      if (!rx_agc_hold && hi_q && gain_q != '0)
        gain_d = gain_q - 1'b1;
      else if (!rx_agc_hold && lo_q && gain_q < GAIN_W'(GAIN_MAX))
        gain_d = gain_q + 1'b1;
      if (gain_d != gain_q) begin
        lock_cnt_d = '0;
        lock_d     = 1'b0;
      end else begin
        if (lock_cnt_q != LK_W'(LOCK_WINS))
          lock_cnt_d = lock_cnt_q + 1'b1;
        lock_d = (lock_cnt_d == LK_W'(LOCK_WINS));
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      wcnt_q     <= '1;
      hcnt_q     <= '0;
      win_end_q  <= 1'b0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      gain_q     <= GAIN_W'(GAIN_INIT);
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
      src_q      <= '0;
      src_vld_q  <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      hcnt_q     <= hcnt_d;
      win_end_q  <= win_end_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      gain_q     <= gain_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
      src_q      <= src_d;
      src_vld_q  <= x_vld;
    end
  end

  assign tx_src      = src_q;
  assign tx_src_vld  = src_vld_q;
  assign tx_agc_gain = gain_q;
  assign tx_agc_lock = lock_q;

endmodule
